// File: rtl/shiftio_pkg.sv
// rtl/shiftio_pkg.sv - shared constants and FSM encoding for the serial shift link
package shiftio_pkg;

  // Frame length and synchronizer depth used by both ends of the link.
  localparam int DEF_WIDTH       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // Receiver frame FSM.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_OVERRUN = 2'd2
  } shiftin_state_t;

  // Bit counter width: must hold WIDTH itself so a full frame is distinguishable from overrun.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shiftin_if.sv
// rtl/shiftin_if.sv - serial input lines and received-word outputs of the shift receiver
interface shiftin_if
  import shiftio_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             sclk_in;
  logic             sdata_in;
  logic             slatch_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             error_out;
  logic             busy_out;

  // Transmitter / consumer side.
  modport master (
    output sclk_in,
    output sdata_in,
    output slatch_in,
    input  data_out,
    input  valid_out,
    input  error_out,
    input  busy_out
  );

  // Receiver side.
  modport slave (
    input  sclk_in,
    input  sdata_in,
    input  slatch_in,
    output data_out,
    output valid_out,
    output error_out,
    output busy_out
  );

endinterface

// File: rtl/shiftin_sync_edge.sv
// rtl/shiftin_sync_edge.sv - multi-flop synchronizer with rise/fall detection
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic resetn_in,
  input  logic d_in,
  output logic rise_out,
  output logic fall_out
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              level;

  assign level = sync_q[STAGES-1];

  // Synchronizer chain plus one delayed copy; reset to the idle line level so release makes no edge.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_in};
      prev_q <= level;
    end
  end

  assign rise_out = level & ~prev_q;
  assign fall_out = ~level & prev_q;

endmodule

// File: rtl/shiftin.sv
// rtl/shiftin.sv - latch-framed serial-to-parallel receiver, MSB first
module shiftin
  import shiftio_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic     clk_in,
  input  logic     resetn_in,
  shiftin_if.slave bus
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  FULL = CW'(WIDTH);

  logic                   sclk_rise;
  logic                   sclk_fall_unused;
  logic                   latch_rise;
  logic                   latch_fall;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   sdata_q;

  shiftin_state_t         state_q, state_n;
  logic [CW-1:0]          cnt_q, cnt_n, cnt_v;
  logic [WIDTH-1:0]       sh_q, sh_n, sh_v;
  logic [WIDTH-1:0]       data_q, data_n;
  logic                   valid_q, valid_n;
  logic                   error_q, error_n;
  logic                   overrun_bit;

  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sclk_sync (
    .clk_in    (clk_in),
    .resetn_in (resetn_in),
    .d_in      (bus.sclk_in),
    .rise_out  (sclk_rise),
    .fall_out  (sclk_fall_unused)
  );

  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_latch_sync (
    .clk_in    (clk_in),
    .resetn_in (resetn_in),
    .d_in      (bus.slatch_in),
    .rise_out  (latch_rise),
    .fall_out  (latch_fall)
  );

  // Data uses the same depth as sclk so the bit seen here lines up with the detected sclk rise.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      sdata_sync <= '0;
    end else begin
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], bus.sdata_in};
    end
  end

  assign sdata_q = sdata_sync[SYNC_STAGES-1];

  // Frame state, shift register, bit counter and registered outputs.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sh_q    <= sh_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      error_q <= error_n;
    end
  end

  // Next-state logic: a bit arriving with the latch rise is counted before the frame is judged.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    sh_n        = sh_q;
    data_n      = data_q;
    valid_n     = 1'b0;
    error_n     = 1'b0;
    cnt_v       = cnt_q;
    sh_v        = sh_q;
    overrun_bit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (latch_fall) begin
          state_n = ST_RECEIVE;
          cnt_n   = '0;
          sh_n    = '0;
        end
      end

      ST_RECEIVE: begin
        if (sclk_rise) begin
          if (cnt_q == FULL) begin
            overrun_bit = 1'b1;
          end else begin
            sh_v  = {sh_q[WIDTH-2:0], sdata_q};
            cnt_v = cnt_q + 1'b1;
          end
        end
        sh_n  = sh_v;
        cnt_n = cnt_v;
        if (latch_rise) begin
          state_n = ST_IDLE;
          if (!overrun_bit && cnt_v == FULL) begin
            data_n  = sh_v;
            valid_n = 1'b1;
          end else begin
            error_n = 1'b1;
          end
        end else if (overrun_bit) begin
          state_n = ST_OVERRUN;
        end
      end

      ST_OVERRUN: begin
        if (latch_rise) begin
          state_n = ST_IDLE;
          error_n = 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.error_out = error_q;
  assign bus.busy_out  = (state_q != ST_IDLE);

endmodule
